inport_debouncer: RTL and testbench

- Input-side counterpart to the outport/seven-segment path.
- Conditions the 8 raw DE0-CV slide switches into a clean 32-bit value for the datapath input port.
- Raw switch lines pass through a 2-flop synchroniser and then a settle counter. A value is committed only after it has been stable for DEBOUNCE_CYCLES cycles.
- out_ready is set on each commit and cleared when the control unit reads the port (in_inport_read).

---
 rtl/inport_debouncer.sv | 154 +++++++++++++++
 tb/tb_inport_debouncer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inport_debouncer.sv
// -----------------------------------------------------------------------------
// inport_debouncer
//
// Purpose:
//    Turns the raw DE0-CV slide switches into a clean 32-bit value for the
//    datapath input port. The switch lines are first synchronised with two
//    flops. A settle counter then watches the synchronised value. A new value
//    is committed to out_inport only after it has stayed unchanged for
//    DEBOUNCE_CYCLES consecutive cycles. out_ready flags a committed value that
//    the control unit has not read yet.
//
// Parameters:
//    DATA_WIDTH       number of switch lines. The committed value is
//                     zero-extended to 32 bits.
//    DEBOUNCE_CYCLES  number of stable cycles needed before a commit. The
//                     legal range is 1..65535.
//    CNT_WIDTH        width of the settle counter. It must hold
//                     DEBOUNCE_CYCLES-1.
//
// Ports:
//    clk             system clock. All state changes on the rising edge.
//    reset           asynchronous, active-high reset.
//    in_switch       raw, asynchronous switch levels.
//    in_inport_read  read strobe from the control unit. It clears out_ready.
//    out_inport      committed value, {zeros, data}.
//    out_ready       a committed value has not been read yet.
//    out_overrun     a commit overwrote a value that was never read.
//
// Build option:
//    INPORT_OVERRUN_EN  When this macro is defined, the sticky overrun flag is
//                       built. When it is not defined, out_overrun is tied to 0.
// -----------------------------------------------------------------------------
module inport_debouncer #(
   parameter int DATA_WIDTH      = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_switch,
   input  logic                  in_inport_read,
   output logic [31:0]           out_inport,
   output logic                  out_ready,
   output logic                  out_overrun
);

   typedef enum logic {
      STABLE = 1'b0,
      SETTLE = 1'b1
   } state_t;

   // This is the counter value on the last cycle of the settle period.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [DATA_WIDTH-1:0] sync1_q;
   logic [DATA_WIDTH-1:0] sync2_q;
   logic [DATA_WIDTH-1:0] cand_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   state_t                state_q;
   logic                  ready_q;

   logic changed;
   logic settle_done;
   logic commit;

   // Two-flop synchroniser. sync1_q feeds only sync2_q. This gives the first
   // flop a full cycle to resolve metastability.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= in_switch;
         sync2_q <= sync1_q;
      end
   end

   // settle_done marks the final cycle of an uninterrupted settle period.
   // commit is asserted only if the settled value differs from the committed
   // one. A bounce that returns to the old value therefore settles silently.
   always_comb begin
      changed     = (sync2_q != cand_q);
      settle_done = !changed && (state_q == SETTLE) && (cnt_q == CNT_LAST);
      commit      = settle_done && (cand_q != data_q);
   end

   // Debounce FSM. Any change on the synchronised value restarts the settle
   // period, whatever the current state. The counter never runs past
   // CNT_LAST, because the FSM leaves SETTLE on that cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         state_q <= STABLE;
         ready_q <= 1'b0;
      end else begin
         if (changed) begin
            cand_q  <= sync2_q;
            cnt_q   <= '0;
            state_q <= SETTLE;
         end else if (settle_done) begin
            state_q <= STABLE;
            if (commit) begin
               data_q <= cand_q;
            end
         end else if (state_q == SETTLE) begin
            cnt_q <= cnt_q + 1'b1;
         end

         // A commit in the same cycle as a read wins. The new value has not
         // been seen by the control unit yet.
         if (commit) begin
            ready_q <= 1'b1;
         end else if (in_inport_read) begin
            ready_q <= 1'b0;
         end
      end
   end

   // Zero-extend the committed value onto the 32-bit port.
   for (genvar gi = 0; gi < 32; gi++) begin : g_out
      if (gi < DATA_WIDTH) begin : g_data
         assign out_inport[gi] = data_q[gi];
      end else begin : g_zero
         assign out_inport[gi] = 1'b0;
      end
   end

   assign out_ready = ready_q;

`ifdef INPORT_OVERRUN_EN
   logic overrun_q;

   // The flag is set when a commit lands on an unread value. It stays set
   // until the next read. A read in the commit cycle consumes the old value,
   // so that case is not an overrun.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_q <= 1'b0;
      end else if (commit && ready_q && !in_inport_read) begin
         overrun_q <= 1'b1;
      end else if (in_inport_read) begin
         overrun_q <= 1'b0;
      end
   end

   assign out_overrun = overrun_q;
`else
   assign out_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_inport_debouncer.sv
// -----------------------------------------------------------------------------
// tb_inport_debouncer
//
// Self-checking bench for inport_debouncer with DEBOUNCE_CYCLES=16.
// Edge counting: in_switch is driven 1 ns after a rising edge. The next rising
// edge is therefore the sampling edge k. The commit lands on edge k+18.
// Outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_inport_debouncer;

   localparam int DC = 16;
`ifdef INPORT_OVERRUN_EN
   localparam logic OVR_EN = 1'b1;
`else
   localparam logic OVR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  sw;
   logic        rd;
   logic [31:0] out_inport;
   logic        out_ready;
   logic        out_overrun;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0]  sw;
      int          hold;
      bit          rd_after;
      logic [31:0] exp_in;
      logic        exp_rdy;
   } vec_t;

   typedef struct {
      logic [31:0] inport;
      logic        rdy;
      logic        ovr;
   } exp_t;

   vec_t vecs[9];
   exp_t sb_q[$];

   inport_debouncer #(
      .DATA_WIDTH      (8),
      .DEBOUNCE_CYCLES (DC),
      .CNT_WIDTH       (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in_switch      (sw),
      .in_inport_read (rd),
      .out_inport     (out_inport),
      .out_ready      (out_ready),
      .out_overrun    (out_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic read_pulse();
      rd = 1'b1;
      step(1);
      rd = 1'b0;
   endtask

   // Drive a new value. Check that nothing changes for edges k..k+17. Then
   // check that the commit appears on edge k+18.
   task automatic expect_commit(input string name, input logic [31:0] old_v, input logic [7:0] new_sw);
      sw = new_sw;
      for (int i = 0; i < DC + 2; i++) begin
         step(1);
         chk({name, " pre inport"}, out_inport, old_v);
         chk({name, " pre ready"}, {31'd0, out_ready}, 32'd0);
      end
      step(1);
      chk({name, " inport"}, out_inport, {24'd0, new_sw});
      chk({name, " ready"}, {31'd0, out_ready}, 32'd1);
      $display("txn %s: commit inport=%h ready=%b", name, out_inport, out_ready);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;

      vecs[0] = '{8'h88,  5, 1'b1, 32'h88, 1'b1};
      vecs[1] = '{8'h88,  5, 1'b0, 32'h88, 1'b0};
      vecs[2] = '{8'h5A, 17, 1'b0, 32'h88, 1'b0};
      vecs[3] = '{8'h5A,  1, 1'b0, 32'h88, 1'b0};
      vecs[4] = '{8'h5A,  1, 1'b0, 32'h5A, 1'b1};
      vecs[5] = '{8'h5A, 10, 1'b1, 32'h5A, 1'b1};
      vecs[6] = '{8'hC3, 30, 1'b1, 32'hC3, 1'b1};
      vecs[7] = '{8'h00, 30, 1'b1, 32'h00, 1'b1};
      vecs[8] = '{8'h00,  5, 1'b0, 32'h00, 1'b0};

      // Reset state.
      reset = 1'b1;
      sw    = 8'h00;
      rd    = 1'b0;
      #1;
      chk("reset inport", out_inport, 32'd0);
      chk("reset ready", {31'd0, out_ready}, 32'd0);
      chk("reset overrun", {31'd0, out_overrun}, 32'd0);
      step(2);
      reset = 1'b0;

      // 1: first commit after reset, checked edge by edge.
      expect_commit("t1", 32'd0, 8'h88);

      // Table-driven transactions, checked through the scoreboard.
      for (int v = 0; v < 9; v++) begin
         sw = vecs[v].sw;
         sb_q.push_back('{vecs[v].exp_in, vecs[v].exp_rdy, 1'b0});
         step(vecs[v].hold);
         if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL vec%0d: scoreboard empty", v);
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("vec%0d inport", v), out_inport, e.inport);
            chk($sformatf("vec%0d ready", v), {31'd0, out_ready}, {31'd0, e.rdy});
            chk($sformatf("vec%0d overrun", v), {31'd0, out_overrun}, {31'd0, e.ovr});
         end
         $display("txn vec%0d: sw=%h inport=%h ready=%b", v, sw, out_inport, out_ready);
         if (vecs[v].rd_after) read_pulse();
      end

      // 2: toggling every 5 cycles must never commit.
      for (int seg = 0; seg < 20; seg++) begin
         sw = (seg % 2 == 0) ? 8'h88 : 8'h00;
         for (int c = 0; c < 5; c++) begin
            step(1);
            chk("t2 toggle inport", out_inport, 32'h00);
            chk("t2 toggle ready", {31'd0, out_ready}, 32'd0);
         end
      end
      $display("txn t2: toggling done inport=%h", out_inport);
      expect_commit("t2", 32'h00, 8'h3C);
      read_pulse();

      // 3: a glitch that returns to the committed value produces no commit.
      sw = 8'h3D;
      step(4);
      sw = 8'h3C;
      for (int c = 0; c < 30; c++) begin
         step(1);
         chk("t3 inport", out_inport, 32'h3C);
         chk("t3 ready", {31'd0, out_ready}, 32'd0);
      end
      $display("txn t3: glitch ignored inport=%h", out_inport);

      // 4: a read on the exact commit edge; the commit wins.
      sw = 8'h01;
      step(DC + 2);
      chk("t4 pre inport", out_inport, 32'h3C);
      chk("t4 pre ready", {31'd0, out_ready}, 32'd0);
      rd = 1'b1;
      step(1);
      rd = 1'b0;
      chk("t4 commit inport", out_inport, 32'h01);
      chk("t4 commit ready", {31'd0, out_ready}, 32'd1);
      read_pulse();
      chk("t4 after read ready", {31'd0, out_ready}, 32'd0);
      $display("txn t4: read on commit inport=%h", out_inport);

      // 5: asynchronous reset during SETTLE at cnt=10.
      sw = 8'hFF;
      step(13);
      chk("t5 pre inport", out_inport, 32'h01);
      reset = 1'b1;
      #1;
      chk("t5 reset inport", out_inport, 32'd0);
      chk("t5 reset ready", {31'd0, out_ready}, 32'd0);
      chk("t5 reset overrun", {31'd0, out_overrun}, 32'd0);
      step(2);
      reset = 1'b0;
      expect_commit("t5", 32'd0, 8'hFF);

      // 6: two commits with no read between them.
      read_pulse();
      sw = 8'h11;
      step(25);
      chk("t6 first inport", out_inport, 32'h11);
      chk("t6 first ready", {31'd0, out_ready}, 32'd1);
      chk("t6 first overrun", {31'd0, out_overrun}, 32'd0);
      sw = 8'h22;
      step(25);
      chk("t6 second inport", out_inport, 32'h22);
      chk("t6 second ready", {31'd0, out_ready}, 32'd1);
      chk("t6 second overrun", {31'd0, out_overrun}, {31'd0, OVR_EN});
      read_pulse();
      chk("t6 read ready", {31'd0, out_ready}, 32'd0);
      chk("t6 read overrun", {31'd0, out_overrun}, 32'd0);
      $display("txn t6: overrun sequence inport=%h", out_inport);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
